// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the RV32M execution unit: aluop codes, FSM states
// and the fixed results of the divide special cases.
package ex_muldiv_pkg;

   localparam int MD_XLEN = 32;

   // aluop = {funct7[5], funct7[0], funct3}; M ops always carry bit3=1
   localparam logic [4:0] ALU_MUL    = 5'b01000;
   localparam logic [4:0] ALU_MULH   = 5'b01001;
   localparam logic [4:0] ALU_MULHSU = 5'b01010;
   localparam logic [4:0] ALU_MULHU  = 5'b01011;
   localparam logic [4:0] ALU_DIV    = 5'b01100;
   localparam logic [4:0] ALU_DIVU   = 5'b01101;
   localparam logic [4:0] ALU_REM    = 5'b01110;
   localparam logic [4:0] ALU_REMU   = 5'b01111;

   localparam logic [MD_XLEN-1:0] DIV_BY_ZERO_Q = '1;
   localparam logic [MD_XLEN-1:0] INT_MIN       = {1'b1, {(MD_XLEN-1){1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_SPECIAL,
      ST_DIV,
      ST_FIX
   } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit_div_core.sv
// Iterative radix-2 restoring divider on unsigned magnitudes; one quotient
// bit per cycle, XLEN cycles after load.
module muldiv_div_core #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            load_i,
   input  logic            kill_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic            done_o,
   output logic [XLEN-1:0] quotient_o,
   output logic [XLEN-1:0] remainder_o
);

   localparam int CW = $clog2(XLEN + 1);

   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;

   always_comb begin
      shifted = {rem_q, quo_q[XLEN-1]};
      diff    = shifted - {1'b0, dvs_q};
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      if (kill_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = CW'(XLEN);
         quo_d = dividend_i;
         rem_d = '0;
         dvs_d = divisor_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
         // a set borrow bit means the trial subtraction went negative
         if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
         end else begin
            rem_d = shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
      end
   end

   // high during the final iteration; outputs are final from the next cycle
   assign done_o      = (cnt_q == CW'(1));
   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M EX-stage unit: single-cycle multiply, iterative divide/remainder with
// RISC-V special-case results and registered outputs.
//
// state   | meaning
// IDLE    | waiting for an accepted M op
// MUL     | multiply result presented (result_valid high)
// SPECIAL | div-by-zero / overflow result presented
// DIV     | divider iterating, one bit per cycle
// FIX     | applying quotient/remainder sign, result registered
import ex_muldiv_pkg::*;

module ex_muldiv_unit #(
   parameter int XLEN = MD_XLEN
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [4:0]      aluop,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic            flush,
   output logic [XLEN-1:0] result,
   output logic            result_valid,
   output logic            busy
);

   md_state_e       state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            valid_q, valid_d;
   logic            q_neg_q, q_neg_d;
   logic            r_neg_q, r_neg_d;
   logic            is_rem_q, is_rem_d;

   logic            is_m_op, accept;
   logic [2:0]      funct3;
   logic            is_div, div_signed, is_rem_op, a_neg, b_neg;
   logic            div_zero, div_ovf;
   logic [XLEN-1:0] a_mag, b_mag, special_res, mul_res, fix_res;
   logic            mul_a_signed, mul_b_signed;
   logic [2*XLEN+1:0] a_ext, b_ext;
   logic [2*XLEN-1:0] prod;
   logic            div_load, div_kill, div_done;
   logic [XLEN-1:0] div_quo, div_rem;

   always_comb begin
      casez (aluop)
         5'b?1???: is_m_op = 1'b1;
         default:  is_m_op = 1'b0;
      endcase
   end

   assign funct3     = aluop[2:0];
   assign accept     = start && is_m_op && (state_q == ST_IDLE) && !flush;
   assign is_div     = funct3[2];
   assign div_signed = (funct3 == ALU_DIV[2:0]) || (funct3 == ALU_REM[2:0]);
   assign is_rem_op  = (funct3 == ALU_REM[2:0]) || (funct3 == ALU_REMU[2:0]);
   assign a_neg      = div_signed && operand_a[XLEN-1];
   assign b_neg      = div_signed && operand_b[XLEN-1];
   assign a_mag      = a_neg ? -operand_a : operand_a;
   assign b_mag      = b_neg ? -operand_b : operand_b;
   assign div_zero   = (operand_b == '0);
   assign div_ovf    = div_signed && (operand_a == XLEN'(INT_MIN)) && (operand_b == '1);

   assign special_res = div_zero ? (is_rem_op ? operand_a : XLEN'(DIV_BY_ZERO_Q))
                                 : (is_rem_op ? '0 : XLEN'(INT_MIN));

   // extension to 2*XLEN+2 bits makes one unsigned multiply serve all signedness mixes
   assign mul_a_signed = (funct3 == ALU_MULH[2:0]) || (funct3 == ALU_MULHSU[2:0]);
   assign mul_b_signed = (funct3 == ALU_MULH[2:0]);
   assign a_ext   = {{(XLEN+2){mul_a_signed && operand_a[XLEN-1]}}, operand_a};
   assign b_ext   = {{(XLEN+2){mul_b_signed && operand_b[XLEN-1]}}, operand_b};
   assign prod    = (2*XLEN)'(a_ext * b_ext);
   assign mul_res = (funct3 == ALU_MUL[2:0]) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

   assign fix_res = is_rem_q ? (r_neg_q ? -div_rem : div_rem)
                             : (q_neg_q ? -div_quo : div_quo);

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      valid_d  = 1'b0;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      is_rem_d = is_rem_q;
      div_load = 1'b0;
      div_kill = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (!is_div) begin
                  state_d  = ST_MUL;
                  result_d = mul_res;
                  valid_d  = 1'b1;
               end else if (div_zero || div_ovf) begin
                  state_d  = ST_SPECIAL;
                  result_d = special_res;
                  valid_d  = 1'b1;
               end else begin
                  state_d  = ST_DIV;
                  div_load = 1'b1;
                  q_neg_d  = a_neg ^ b_neg;
                  r_neg_d  = a_neg;
                  is_rem_d = is_rem_op;
               end
            end
         end
         ST_MUL, ST_SPECIAL: state_d = ST_IDLE;
         ST_DIV: begin
            if (flush) begin
               state_d  = ST_IDLE;
               div_kill = 1'b1;
            end else if (div_done) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            if (!flush) begin
               result_d = fix_res;
               valid_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         valid_q  <= 1'b0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         is_rem_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         is_rem_q <= is_rem_d;
      end
   end

   muldiv_div_core #(.XLEN(XLEN)) u_div_core (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_i      (div_load),
      .kill_i      (div_kill),
      .dividend_i  (a_mag),
      .divisor_i   (b_mag),
      .done_o      (div_done),
      .quotient_o  (div_quo),
      .remainder_o (div_rem)
   );

   assign result       = result_q;
   assign result_valid = valid_q;
   assign busy         = (state_q == ST_DIV) || (state_q == ST_FIX);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: a reference model queues result and
// latency per issued op; a monitor pops on every result_valid.
module tb_ex_muldiv_unit;
   import ex_muldiv_pkg::*;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            start = 1'b0;
   logic            flush = 1'b0;
   logic [4:0]      aluop = '0;
   logic [XLEN-1:0] operand_a = '0;
   logic [XLEN-1:0] operand_b = '0;
   logic [XLEN-1:0] result;
   logic            result_valid;
   logic            busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] val;
      int          t0;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   ex_muldiv_unit #(.XLEN(XLEN)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .aluop        (aluop),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .flush        (flush),
      .result       (result),
      .result_valid (result_valid),
      .busy         (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      p  = '0;
      case (op)
         ALU_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
         ALU_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
         ALU_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
         ALU_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
         ALU_DIV:    return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
         ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         ALU_REM:    return (b == 0) ? a : 32'(sa % sb);
         ALU_REMU:   return (b == 0) ? a : a % b;
         default:    return 32'd0;
      endcase
   endfunction

   function automatic int model_lat(input logic [4:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
      if (!op[2]) return 1;
      if (b == 0) return 1;
      if ((op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return 1;
      return XLEN + 2;
   endfunction

   always @(posedge clk) begin
      #1;
      if (result_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'(result_valid), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("result", result, mon_e.val);
            chk("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op and walk it to completion; pulse_k>0 re-pulses start in that cycle.
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int pulse_k);
      int   lat;
      exp_t e;
      lat       = model_lat(op, a, b);
      start     = 1'b1;
      aluop     = op;
      operand_a = a;
      operand_b = b;
      e.val = model(op, a, b);
      e.t0  = cyc;
      e.lat = lat;
      exp_q.push_back(e);
      chk("busy_c0", 32'(busy), 32'd0);
      step();
      start     = 1'b0;
      operand_a = $urandom();
      operand_b = $urandom();
      for (int k = 1; k <= lat; k++) begin
         chk("busy", 32'(busy), 32'(k < lat));
         if (k == lat) chk("valid_at_lat", 32'(result_valid), 32'd1);
         if (k == pulse_k) begin
            start = 1'b1;
            aluop = ALU_MUL;
         end else begin
            start = 1'b0;
         end
         step();
      end
      start = 1'b0;
   endtask

   task automatic expect_quiet(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         chk(tag, {30'd0, busy, result_valid}, 32'd0);
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result", result, 32'd0);
      chk("rst_valid", 32'(result_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      step();

      // multiply signedness
      issue(ALU_MUL,    32'hFFFF_FFFF, 32'd2, 0);
      issue(ALU_MULH,   32'hFFFF_FFFF, 32'd2, 0);
      issue(ALU_MULHSU, 32'hFFFF_FFFF, 32'd2, 0);
      issue(ALU_MULHU,  32'hFFFF_FFFF, 32'd2, 0);

      // signed divide, negative dividend
      issue(ALU_DIV, 32'hFFFF_FFEC, 32'd3, 0);
      issue(ALU_REM, 32'hFFFF_FFEC, 32'd3, 0);

      // divide by zero and signed overflow
      issue(ALU_DIVU, 32'd123, 32'd0, 0);
      issue(ALU_REMU, 32'd123, 32'd0, 0);
      issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      issue(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);

      // reset mid-divide
      start = 1'b1; aluop = ALU_DIV; operand_a = 32'd100; operand_b = 32'd7;
      step();
      start = 1'b0;
      repeat (9) step();
      chk("busy_before_reset", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_result", result, 32'd0);
      chk("rst_mid_valid", 32'(result_valid), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      step();
      step();
      reset_n = 1'b1;
      expect_quiet("after_reset_quiet", 40);

      // flush during divide at cycle 5
      start = 1'b1; aluop = ALU_DIVU; operand_a = 32'd1000; operand_b = 32'd10;
      step();
      start = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         chk("busy_pre_flush", 32'(busy), 32'd1);
         if (k == 5) flush = 1'b1;
         step();
      end
      flush = 1'b0;
      expect_quiet("after_flush_quiet", 40);

      // non-M op ignored
      start = 1'b1; aluop = 5'b00000; operand_a = 32'd1; operand_b = 32'd2;
      step();
      start = 1'b0;
      expect_quiet("add_ignored", 4);

      // flush coincident with start: not accepted
      start = 1'b1; flush = 1'b1; aluop = ALU_MUL; operand_a = 32'd3; operand_b = 32'd4;
      step();
      start = 1'b0; flush = 1'b0;
      expect_quiet("flush_at_accept", 4);

      // flush in FIX suppresses the pulse
      start = 1'b1; aluop = ALU_DIVU; operand_a = 32'd77; operand_b = 32'd5;
      step();
      start = 1'b0;
      repeat (32) step();
      chk("busy_in_fix", 32'(busy), 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      expect_quiet("fix_flush_quiet", 6);

      // start pulsed while busy is ignored; divide still completes
      issue(ALU_DIVU, 32'd1000, 32'd10, 10);

      // random mix
      for (int i = 0; i < 10; i++) begin
         logic [4:0]  rop;
         logic [31:0] ra, rb;
         rop = {2'b01, 3'($urandom_range(0, 7))};
         ra  = $urandom();
         rb  = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom();
         if (i % 4 == 1) ra = 32'h8000_0000;
         issue(rop, ra, rb, 0);
      end

      repeat (3) step();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- EX-stage execution unit for the RV32M operations.
- Consumes the 5-bit aluop produced in ID, where aluop = {funct7[5], funct7[0], funct3}; only codes with aluop[3]=1 are handled here.
- Multiplies complete in one cycle. Divides and remainders use an iterative radix-2 restoring divider.
- busy is exported so the hazard unit can hold IF/ID/EX while a divide runs.

Parameters:
XLEN, 32, operand/result width; the divide iteration count equals XLEN

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  EX holds a valid instruction for this unit this cycle
aluop  input  5  operation code from ID; aluop[3]=1 selects M ops, aluop[2:0]=funct3
operand_a  input  XLEN  rs1 value (after forwarding)
operand_b  input  XLEN  rs2 value (after forwarding)
flush  input  1  kill the in-flight operation (branch mispredict/exception)
result  output  XLEN  registered result
result_valid  output  1  one-cycle pulse; result is valid in the same cycle
busy  output  1  operation accepted and not yet completed

Behaviour:
- Interface: one clock, clk. reset_n is asynchronous and active-low.
- Reset (async): state=IDLE; result=0, result_valid=0, busy=0, iteration counter=0.
- Accept condition: start && aluop[3] && state==IDLE && !flush.
  - start with aluop[3]=0 is ignored.
  - start while busy is ignored; the hazard unit guarantees it holds.
- aluop[2:0] decode:
  - 000 MUL: low XLEN bits of product
  - 001 MULH: signed x signed, high bits
  - 010 MULHSU: signed a x unsigned b, high bits
  - 011 MULHU: unsigned x unsigned, high bits
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- Multiply arithmetic:
  - Operands are extended to 2*XLEN+2 bits according to signedness.
  - The product is truncated to the 2*XLEN-bit window, then low or high half is selected.
- States:
  - IDLE -> MUL on accept of a multiply.
  - IDLE -> SPECIAL on accept of a div/rem with operand_b==0 or signed overflow.
  - IDLE -> DIV otherwise.
  - MUL -> IDLE, with result_valid pulsed.
  - SPECIAL -> IDLE, with result_valid pulsed.
  - DIV -> DIV for XLEN iterations, then -> FIX.
  - FIX -> IDLE, with result_valid pulsed.
- Latency, counting the accept cycle as cycle 0:
  - MUL/MULH*: result_valid in cycle 1.
  - Special cases: result_valid in cycle 1.
  - Normal div/rem: XLEN iterations in cycles 1..XLEN, sign fix in FIX, result_valid in cycle XLEN+2 (34 for XLEN=32).
- busy:
  - 0 in the accept cycle; the hazard unit uses the combinational start term for that cycle.
  - 1 from cycle 1 until the cycle before result_valid.
  - 0 in the result_valid cycle.
- Divider operation:
  - Latches the magnitudes |a| and |b| (absolute value only for signed ops), the result sign flags, and the op.
  - Each DIV cycle shifts the remainder:quotient pair left by one, trial-subtracts the divisor, and sets the quotient bit if the trial is non-negative.
  - FIX negates the quotient if sign(a)!=sign(b) for DIV; negates the remainder if a<0 for REM.
- Special cases (RISC-V spec):
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give operand_a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM only): DIV gives 0x80000000, REM gives 0.
- result is held after result_valid until the next completion. result_valid is a single-cycle pulse.
- flush:
  - In any state, the next edge goes to IDLE with busy=0 and no result_valid pulse.
  - flush coincident with a would-be accept: no accept.
  - flush in the cycle a completion would pulse: the pulse is suppressed.
- reset_n asserted mid-divide: immediate return to IDLE; a partial result is never emitted.
- No combinational path from inputs to any output.

Decomposition:
- Shared package/encodings header holds:
  - the M-op aluop constants (ALU_MUL..ALU_REMU, 5-bit with bit3=1)
  - the state encoding
  - the constants DIV_BY_ZERO_Q (all ones) and INT_MIN
- Sub-module muldiv_div_core:
  - iterative unsigned divider with load/done handshake
  - XLEN-cycle count, quotient/remainder outputs
  - instantiated once
- Sign handling, special-case detection and the multiplier stay in ex_muldiv_unit.

Test Plan:
1. Reset mid-divide:
   - Stimulus: start DIV 100/7, assert reset_n=0 at cycle 10, release, then wait 40 cycles.
   - Required response: outputs 0 during reset; no result_valid after release.
2. Multiply signedness:
   - Stimulus: a=0xFFFFFFFF, b=2, run MUL, MULH, MULHSU, MULHU in turn.
   - Required response: 0xFFFFFFFE, 0xFFFFFFFF, 0xFFFFFFFF, 0x00000001 respectively, each with result_valid in cycle 1.
3. Signed divide with negative dividend:
   - Stimulus: DIV a=-20 (0xFFFFFFEC), b=3; then REM with the same operands.
   - Required response: busy high cycles 1..33, result_valid in cycle 34; result 0xFFFFFFFA (-6), then REM gives 0xFFFFFFFE (-2).
4. Divide by zero:
   - Stimulus: DIVU 123/0, then REMU 123/0.
   - Required response: 0xFFFFFFFF, then 123; each result_valid in cycle 1, busy never asserted.
5. Signed overflow:
   - Stimulus: DIV 0x80000000/0xFFFFFFFF, then REM with the same operands.
   - Required response: 0x80000000 and 0 respectively, each with 1-cycle latency.
6. Flush and ignored starts:
   - Stimulus: start DIVU 1000/10, flush at cycle 5; start with aluop=5'b00000 (ADD); start pulsed while busy.
   - Required response: no result_valid in any case; busy=0 from cycle 6 after the flush; the next DIVU 1000/10 returns 100.
